msi_vector_dispatch: RTL and testbench

Sits directly downstream of the MSI generator's AXI4-Lite register slave and turns per-vector interrupt requests into MSI transactions on the PCIe endpoint's configuration interrupt handshake. It edge-detects request lines, latches them as pending, applies the per-vector mask from the register file, and round-robin arbitrates among eligible vectors. It issues one MSI at a time and enforces a programmable hold-off gap between messages.

---
 rtl/msi_vector_dispatch.sv | 157 +++++++++++++++
 tb/tb_msi_vector_dispatch.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/msi_vector_dispatch.sv
// Converts edge-triggered per-vector interrupt requests into round-robin MSI handshakes with a hold-off gap.
// Optional MSI_STATUS_COUNTER_EN adds a saturating accepted-MSI counter on msi_issued_cnt.
module msi_vector_dispatch #(
  parameter int VECTOR_COUNT = 8,
  parameter int HOLDOFF      = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [VECTOR_COUNT-1:0] irq_req,
  input  logic [VECTOR_COUNT-1:0] irq_mask,
  input  logic                    msi_enable,
  input  logic [2:0]              cfg_interrupt_mmenable,
  output logic                    cfg_interrupt,
  output logic [7:0]              cfg_interrupt_di,
  input  logic                    cfg_interrupt_rdy,
  output logic [VECTOR_COUNT-1:0] irq_pending,
  output logic                    busy,
  output logic [15:0]             msi_issued_cnt
);

  localparam int         IW       = (VECTOR_COUNT > 1) ? $clog2(VECTOR_COUNT) : 1;
  localparam logic [7:0] GAP_LAST = (HOLDOFF > 0) ? 8'(HOLDOFF - 1) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GAP
  } state_t;

  state_t                  r_state;
  logic [VECTOR_COUNT-1:0] r_req_q;
  logic [VECTOR_COUNT-1:0] r_pending;
  logic [IW-1:0]           r_granted;
  logic [IW-1:0]           r_last_granted;
  logic [7:0]              r_gap_cnt;
  logic                    r_cfg_interrupt;
  logic [7:0]              r_cfg_di;
  logic                    r_busy;

  logic [VECTOR_COUNT-1:0] w_rise;
  logic [VECTOR_COUNT-1:0] w_eligible;
  logic [VECTOR_COUNT-1:0] w_clear;
  logic                    w_accept;
  logic [IW-1:0]           w_pick;
  logic                    w_pick_valid;
  logic [7:0]              w_di_mask;

  assign w_rise     = irq_req & ~r_req_q;
  assign w_eligible = r_pending & ~irq_mask;
  assign w_accept   = r_cfg_interrupt & cfg_interrupt_rdy;
  assign w_di_mask  = 8'((9'd1 << cfg_interrupt_mmenable) - 9'd1);

  always_comb begin
    w_clear = '0;
    if (w_accept) w_clear[r_granted] = 1'b1;
  end

  // Walk downward so the nearest eligible vector after last_granted wins.
  always_comb begin
    logic [IW-1:0] idx;
    w_pick       = '0;
    w_pick_valid = 1'b0;
    idx          = '0;
    for (int k = VECTOR_COUNT; k >= 1; k--) begin
      idx = IW'((int'(r_last_granted) + k) % VECTOR_COUNT);
      if (w_eligible[idx]) begin
        w_pick       = idx;
        w_pick_valid = 1'b1;
      end
    end
  end

  // A rise on the accept cycle wins over the clear, so the new request survives.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_req_q   <= '0;
      r_pending <= '0;
    end else begin
      r_req_q   <= irq_req;
      r_pending <= (r_pending & ~w_clear) | w_rise;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state         <= S_IDLE;
      r_granted       <= '0;
      r_last_granted  <= IW'(VECTOR_COUNT - 1);
      r_gap_cnt       <= 8'd0;
      r_cfg_interrupt <= 1'b0;
      r_cfg_di        <= 8'd0;
      r_busy          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (msi_enable && w_pick_valid) begin
            r_state         <= S_REQ;
            r_granted       <= w_pick;
            r_cfg_interrupt <= 1'b1;
            r_cfg_di        <= 8'(w_pick) & w_di_mask;
            r_busy          <= 1'b1;
          end
        end
        // Endpoint protocol: once raised, the request is held until rdy regardless of enable/mask.
        S_REQ: begin
          if (cfg_interrupt_rdy) begin
            r_cfg_interrupt <= 1'b0;
            r_cfg_di        <= 8'd0;
            r_last_granted  <= r_granted;
            if (HOLDOFF == 0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= S_GAP;
              r_gap_cnt <= GAP_LAST;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == 8'd0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end
        default: begin
          r_state         <= S_IDLE;
          r_cfg_interrupt <= 1'b0;
          r_busy          <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_interrupt    = r_cfg_interrupt;
  assign cfg_interrupt_di = r_cfg_di;
  assign irq_pending      = r_pending;
  assign busy             = r_busy;

`ifdef MSI_STATUS_COUNTER_EN
  logic [15:0] r_issued_cnt;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_issued_cnt <= 16'd0;
    end else if (w_accept && (r_issued_cnt != 16'hFFFF)) begin
      r_issued_cnt <= r_issued_cnt + 16'd1;
    end
  end

  assign msi_issued_cnt = r_issued_cnt;
`else
  assign msi_issued_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_msi_vector_dispatch.sv
// Self-checking bench for msi_vector_dispatch: directed scenarios then random traffic,
// every cycle compared against a time-based reference model of pending/arbitration/hold-off.
module tb_msi_vector_dispatch;

  localparam int VC = 8;
  localparam int HO = 4;

  logic          ACLK;
  logic          ARESETN;
  logic [VC-1:0] irqReq;
  logic [VC-1:0] irqMask;
  logic          msiEnable;
  logic [2:0]    mmEnable;
  logic          cfgInterrupt;
  logic [7:0]    cfgDi;
  logic          cfgRdy;
  logic [VC-1:0] irqPending;
  logic          busy;
  logic [15:0]   issuedCnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: pending set, previous request levels, arbitration pointer,
  // an in-flight flag and the cycle index at which the hold-off window ends.
  bit [VC-1:0] mPend;
  bit [VC-1:0] mPrev;
  int          mLast;
  int          mGrant;
  bit          mInReq;
  int          mFreeAt;
  int          mCount;
  bit [7:0]    mDi;
  int          cycle = 0;

  msi_vector_dispatch #(
    .VECTOR_COUNT(VC),
    .HOLDOFF     (HO)
  ) dut (
    .ACLK                  (ACLK),
    .ARESETN               (ARESETN),
    .irq_req               (irqReq),
    .irq_mask              (irqMask),
    .msi_enable            (msiEnable),
    .cfg_interrupt_mmenable(mmEnable),
    .cfg_interrupt         (cfgInterrupt),
    .cfg_interrupt_di      (cfgDi),
    .cfg_interrupt_rdy     (cfgRdy),
    .irq_pending           (irqPending),
    .busy                  (busy),
    .msi_issued_cnt        (issuedCnt)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic resetModel();
    mPend   = '0;
    mPrev   = '0;
    mLast   = VC - 1;
    mGrant  = 0;
    mInReq  = 1'b0;
    mFreeAt = -1;
    mCount  = 0;
    mDi     = 8'd0;
  endtask

  // One rising edge of the reference: decisions use the pending set as it stood before the edge.
  task automatic modelEdge();
    bit [VC-1:0] rise;
    bit [VC-1:0] elig;
    cycle++;
    rise  = irqReq & ~mPrev;
    elig  = mPend & ~irqMask;
    mPrev = irqReq;
    if (mInReq && cfgRdy) mPend[mGrant] = 1'b0;
    mPend = mPend | rise;
    if (mInReq) begin
      if (cfgRdy) begin
        mInReq  = 1'b0;
        mLast   = mGrant;
        mFreeAt = cycle + HO;
        if (mCount < 65535) mCount++;
      end
    end else if (cycle > mFreeAt && msiEnable && elig != '0) begin
      for (int k = 1; k <= VC; k++) begin
        int v;
        v = (mLast + k) % VC;
        if (elig[v]) begin
          mGrant = v;
          break;
        end
      end
      mInReq = 1'b1;
      mDi    = 8'(mGrant & ((1 << mmEnable) - 1));
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic checkOutput(input string tag);
    int expCnt;
`ifdef MSI_STATUS_COUNTER_EN
    expCnt = mCount;
`else
    expCnt = 0;
`endif
    checkValue({tag, "/cfg_interrupt"}, 32'(cfgInterrupt), 32'(mInReq));
    checkValue({tag, "/cfg_interrupt_di"}, 32'(cfgDi), mInReq ? 32'(mDi) : 32'd0);
    checkValue({tag, "/irq_pending"}, 32'(irqPending), 32'(mPend));
    checkValue({tag, "/busy"}, 32'(busy), 32'(mInReq || (cycle < mFreeAt)));
    checkValue({tag, "/msi_issued_cnt"}, 32'(issuedCnt), 32'(expCnt));
  endtask

  // Drive inputs, take one clock edge, advance the model, then check just after the edge.
  task automatic applyStimulus(input string tag, input logic [VC-1:0] req, input logic [VC-1:0] mask,
                               input logic en, input logic [2:0] mmen, input logic rdy);
    irqReq    = req;
    irqMask   = mask;
    msiEnable = en;
    mmEnable  = mmen;
    cfgRdy    = rdy;
    @(posedge ACLK);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    int expCnt3;
    logic [VC-1:0] rMask;
    logic [2:0]    rMm;
`ifdef MSI_STATUS_COUNTER_EN
    expCnt3 = 3;
`else
    expCnt3 = 0;
`endif
    ARESETN   = 1'b0;
    irqReq    = '0;
    irqMask   = '0;
    msiEnable = 1'b1;
    mmEnable  = 3'd3;
    cfgRdy    = 1'b0;
    resetModel();
    #2;
    checkOutput("reset");
    @(negedge ACLK);
    ARESETN = 1'b1;

    $display("[TB] single request");
    for (int i = 0; i < 3; i++) applyStimulus("idle", '0, '0, 1'b1, 3'd3, 1'b0);
    applyStimulus("single_pulse", 8'h04, '0, 1'b1, 3'd3, 1'b0);
    checkValue("single_pending2", 32'(irqPending[2]), 32'd1);
    applyStimulus("single_req", 8'h00, '0, 1'b1, 3'd3, 1'b0);
    checkValue("single_cfg_int", 32'(cfgInterrupt), 32'd1);
    checkValue("single_di", 32'(cfgDi), 32'h02);
    for (int i = 0; i < 2; i++) applyStimulus("single_wait", '0, '0, 1'b1, 3'd3, 1'b0);
    applyStimulus("single_accept", '0, '0, 1'b1, 3'd3, 1'b1);
    checkValue("single_cleared", 32'(irqPending), 32'd0);
    for (int i = 0; i < 8; i++) applyStimulus("single_gap", '0, '0, 1'b1, 3'd3, 1'b1);

    $display("[TB] round-robin burst");
    applyStimulus("rr_burst", 8'hFF, '0, 1'b1, 3'd3, 1'b1);
    for (int i = 0; i < 48; i++) applyStimulus("rr_run", '0, '0, 1'b1, 3'd3, 1'b1);
    checkValue("rr_drained", 32'(irqPending), 32'd0);

    $display("[TB] mask");
    applyStimulus("mask_pulse", 8'h20, 8'h20, 1'b1, 3'd3, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus("mask_hold", '0, 8'h20, 1'b1, 3'd3, 1'b1);
    checkValue("mask_pending5", 32'(irqPending[5]), 32'd1);
    checkValue("mask_no_msi", 32'(cfgInterrupt), 32'd0);
    applyStimulus("mask_clear", '0, '0, 1'b1, 3'd3, 1'b0);
    checkValue("mask_di", 32'(cfgDi), 32'h05);
    for (int i = 0; i < 8; i++) applyStimulus("mask_run", '0, '0, 1'b1, 3'd3, 1'b1);

    $display("[TB] vector truncation");
    applyStimulus("trunc6", 8'h40, '0, 1'b1, 3'd1, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus("trunc6_run", '0, '0, 1'b1, 3'd1, 1'b1);
    applyStimulus("trunc7", 8'h80, '0, 1'b1, 3'd1, 1'b0);
    applyStimulus("trunc7_req", '0, '0, 1'b1, 3'd1, 1'b0);
    checkValue("trunc7_di", 32'(cfgDi), 32'h01);
    for (int i = 0; i < 8; i++) applyStimulus("trunc7_run", '0, '0, 1'b1, 3'd1, 1'b1);

    $display("[TB] enable drop during request and re-pulse on accept");
    applyStimulus("bnd_pulse", 8'h08, '0, 1'b1, 3'd3, 1'b0);
    applyStimulus("bnd_req", '0, '0, 1'b1, 3'd3, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus("bnd_hold", '0, '0, 1'b0, 3'd3, 1'b0);
    checkValue("bnd_held", 32'(cfgInterrupt), 32'd1);
    applyStimulus("bnd_accept", 8'h08, '0, 1'b0, 3'd3, 1'b1);
    checkValue("bnd_pending3", 32'(irqPending[3]), 32'd1);
    for (int i = 0; i < 12; i++) applyStimulus("bnd_second", '0, '0, 1'b1, 3'd3, 1'b1);
    checkValue("bnd_drained", 32'(irqPending), 32'd0);

    $display("[TB] reset mid-request");
    applyStimulus("rst_pulse", 8'h06, '0, 1'b1, 3'd3, 1'b0);
    applyStimulus("rst_req", '0, '0, 1'b1, 3'd3, 1'b0);
    #2;
    ARESETN = 1'b0;
    #1;
    resetModel();
    checkValue("rst_cfg_int", 32'(cfgInterrupt), 32'd0);
    checkValue("rst_pending", 32'(irqPending), 32'd0);
    checkOutput("rst_async");
    @(negedge ACLK);
    ARESETN = 1'b1;
    applyStimulus("cnt_pulse", 8'h13, '0, 1'b1, 3'd3, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus("cnt_run", '0, '0, 1'b1, 3'd3, 1'b1);
    checkValue("cnt_three", 32'(issuedCnt), 32'(expCnt3));

    $display("[TB] random traffic");
    rMask = '0;
    rMm   = 3'd3;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(15) == 0) rMask = VC'($urandom) & VC'($urandom);
      if ($urandom_range(31) == 0) rMm = 3'($urandom_range(7));
      applyStimulus("random", VC'($urandom) & VC'($urandom) & VC'($urandom), rMask,
                    ($urandom_range(7) != 0), rMm, ($urandom_range(2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
